// File: rtl/exec_stage.sv
// Execute stage feeding the register file write port.
// Single-cycle ALU ops produce a registered result one cycle after accept;
// MUL runs an iterative shift-add over WORD edges and back-pressures issue.
// Also owns the Z/C flag register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready to accept; single-cycle ops complete from here
// MUL_RUN | shift-add multiply iterating; in_ready low, busy high
module exec_stage #(
    parameter int WORD   = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [WORD-1:0]   src_a,
    input  logic [WORD-1:0]   src_b,
    input  logic [WORD-1:0]   imm,
    input  logic              use_imm,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic              kill,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD-1:0]   wr_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORD + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WORD);
    // The final shift-add step happens on the edge where the counter drops to 1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2);

    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [2*WORD-1:0]   acc, acc_next;
    logic [2*WORD-1:0]   mcand, mcand_next;
    logic [WORD-1:0]     mplier, mplier_next;
    logic [ADDR_W-1:0]   mul_addr, mul_addr_next;

    logic                wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_next;
    logic [WORD-1:0]     wr_data_next;
    logic                flag_z_next, flag_c_next;

    logic [WORD-1:0]     opb;
    logic [WORD:0]       sum, diff;
    logic [WORD-1:0]     alu_res;
    logic                alu_c;
    logic                alu_we;
    logic [2*WORD-1:0]   partial;

    assign opb  = use_imm ? imm : src_b;
    assign sum  = {1'b0, src_a} + {1'b0, opb};
    assign diff = {1'b0, src_a} - {1'b0, opb};

    assign in_ready = (state == IDLE);
    assign busy     = (state == MUL_RUN);

    // Single-cycle ALU result and carry; alu_we marks ops that write back.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_we  = 1'b1;
        case (op)
            OP_MOV: alu_res = opb;
            OP_ADD: begin alu_res = sum[WORD-1:0];  alu_c = sum[WORD];  end
            OP_SUB: begin alu_res = diff[WORD-1:0]; alu_c = diff[WORD]; end
            OP_AND: alu_res = src_a & opb;
            OP_OR:  alu_res = src_a | opb;
            OP_XOR: alu_res = src_a ^ opb;
            OP_NOT: alu_res = ~src_a;
            OP_SHL: begin alu_res = {src_a[WORD-2:0], 1'b0}; alu_c = src_a[WORD-1]; end
            OP_SHR: begin alu_res = {1'b0, src_a[WORD-1:1]}; alu_c = src_a[0];      end
            default: alu_we = 1'b0;
        endcase
    end

    // One shift-add step: accumulate the multiplicand if the current multiplier bit is set.
    assign partial = acc + (mplier[0] ? mcand : '0);

    // Next-state, multiplier datapath and write-port update.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        acc_next      = acc;
        mcand_next    = mcand;
        mplier_next   = mplier;
        mul_addr_next = mul_addr;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr;
        wr_data_next  = wr_data;
        flag_z_next   = flag_z;
        flag_c_next   = flag_c;
        case (state)
            IDLE: begin
                if (in_valid && !kill) begin
                    if (op == OP_MUL) begin
                        // First multiplier bit is consumed at accept.
                        state_next    = MUL_RUN;
                        cnt_next      = CNT_LOAD;
                        acc_next      = opb[0] ? {{WORD{1'b0}}, src_a} : '0;
                        mcand_next    = {{(WORD-1){1'b0}}, src_a, 1'b0};
                        mplier_next   = {1'b0, opb[WORD-1:1]};
                        mul_addr_next = dst_addr;
                    end else if (alu_we) begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = dst_addr;
                        wr_data_next = alu_res;
                        flag_z_next  = (alu_res == '0);
                        flag_c_next  = alu_c;
                    end
                end
            end
            MUL_RUN: begin
                if (kill) begin
                    state_next = IDLE;
                end else begin
                    cnt_next    = cnt - CNT_W'(1);
                    acc_next    = partial;
                    mcand_next  = {mcand[2*WORD-2:0], 1'b0};
                    mplier_next = {1'b0, mplier[WORD-1:1]};
                    if (cnt == CNT_LAST) begin
                        state_next   = IDLE;
                        wr_en_next   = 1'b1;
                        wr_addr_next = mul_addr;
                        wr_data_next = partial[WORD-1:0];
                        flag_z_next  = (partial[WORD-1:0] == '0);
                        flag_c_next  = (partial[2*WORD-1:WORD] != '0);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, multiplier and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            mul_addr <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            acc      <= acc_next;
            mcand    <= mcand_next;
            mplier   <= mplier_next;
            mul_addr <= mul_addr_next;
            wr_en    <= wr_en_next;
            wr_addr  <= wr_addr_next;
            wr_data  <= wr_data_next;
            flag_z   <= flag_z_next;
            flag_c   <= flag_c_next;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: single-cycle ALU vectors, MUL timing,
// back-to-back issue, kill and asynchronous reset.
module tb_exec_stage;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] src_a, src_b, imm;
    logic       use_imm;
    logic [1:0] dst_addr;
    logic       kill;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       flag_z, flag_c, busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_wr;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, imm;
        logic       ui;
        logic [1:0] dst;
        logic       we;
        logic [1:0] addr;
        logic [7:0] data;
        logic       z, c;
    } vec_t;

    vec_t vecs[13];

    exec_stage #(.WORD(8), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .imm(imm), .use_imm(use_imm),
        .dst_addr(dst_addr), .kill(kill), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] im, input logic ui, input logic [1:0] d);
        op = o; src_a = a; src_b = b; imm = im; use_imm = ui; dst_addr = d;
        in_valid = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [1:0] addr,
                           input logic [7:0] data, input logic z, input logic c);
        chk({tag, ".wr_en"},   32'(wr_en),   32'(we));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(addr));
        chk({tag, ".wr_data"}, 32'(wr_data), 32'(data));
        chk({tag, ".z"},       32'(flag_z),  32'(z));
        chk({tag, ".c"},       32'(flag_c),  32'(c));
    endtask

    initial begin
        //             op     a      b      imm    ui dst we addr data   z  c
        vecs[0]  = '{4'd2,  8'hF0, 8'h20, 8'h00, 0, 1, 1, 1, 8'h10, 0, 1};
        vecs[1]  = '{4'd3,  8'h05, 8'h77, 8'h05, 1, 2, 1, 2, 8'h00, 1, 0};
        vecs[2]  = '{4'd9,  8'h01, 8'h00, 8'h00, 0, 3, 1, 3, 8'h00, 1, 1};
        vecs[3]  = '{4'd0,  8'hFF, 8'hFF, 8'h00, 0, 0, 0, 3, 8'h00, 1, 1};
        vecs[4]  = '{4'd8,  8'h81, 8'h00, 8'h00, 0, 0, 1, 0, 8'h02, 0, 1};
        vecs[5]  = '{4'd3,  8'h03, 8'h05, 8'h00, 0, 1, 1, 1, 8'hFE, 0, 1};
        vecs[6]  = '{4'd4,  8'hF0, 8'h3C, 8'h00, 0, 2, 1, 2, 8'h30, 0, 0};
        vecs[7]  = '{4'd5,  8'h0F, 8'h00, 8'hF0, 1, 3, 1, 3, 8'hFF, 0, 0};
        vecs[8]  = '{4'd6,  8'hAA, 8'hAA, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0};
        vecs[9]  = '{4'd2,  8'hFF, 8'h01, 8'h00, 0, 1, 1, 1, 8'h00, 1, 1};
        vecs[10] = '{4'd1,  8'h00, 8'h5A, 8'h00, 0, 2, 1, 2, 8'h5A, 0, 0};
        vecs[11] = '{4'd7,  8'h0F, 8'h00, 8'h00, 0, 3, 1, 3, 8'hF0, 0, 0};
        vecs[12] = '{4'd13, 8'h00, 8'h00, 8'h00, 0, 0, 0, 3, 8'hF0, 0, 0};

        rst = 1'b1; in_valid = 1'b0; kill = 1'b0;
        op = '0; src_a = '0; src_b = '0; imm = '0; use_imm = 1'b0; dst_addr = '0;

        // Asynchronous reset with the clock stopped.
        #3 rst = 1'b0;
        #1;
        chk_out("reset", 0, 0, 8'h00, 0, 0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.busy",     32'(busy),     32'd0);
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();

        // Single-cycle ops issued back-to-back.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].ui, vecs[i].dst);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].data,
                    vecs[i].z, vecs[i].c);
        end
        in_valid = 1'b0;
        tick();
        chk("idle.wr_en", 32'(wr_en), 32'd0);

        // kill while idle blocks the accept.
        drive(4'd2, 8'h01, 8'h01, 8'h00, 0, 1);
        kill = 1'b1;
        tick();
        in_valid = 1'b0; kill = 1'b0;
        chk_out("kill_idle", 0, 3, 8'hF0, 0, 0);

        // MUL timing, with in_valid pulses ignored while busy.
        drive(4'd10, 8'h0D, 8'h0B, 8'h00, 0, 3);
        tick();
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("mul1.in_ready%0d", k), 32'(in_ready), 32'd0);
            chk($sformatf("mul1.busy%0d", k),     32'(busy),     32'd1);
            chk($sformatf("mul1.wr_en%0d", k),    32'(wr_en),    32'd0);
            if (k >= 2 && k <= 4) drive(4'd2, 8'h11, 8'h22, 8'h00, 0, 0);
            else in_valid = 1'b0;
            tick();
        end
        chk_out("mul1", 1, 3, 8'h8F, 0, 0);
        chk("mul1.in_ready_done", 32'(in_ready), 32'd1);
        tick();
        chk("mul1.after", 32'(wr_en), 32'd0);

        // MUL overflow followed by a back-to-back ADD on the writeback edge.
        drive(4'd10, 8'h20, 8'h10, 8'h00, 0, 0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk_out("mul2", 1, 0, 8'h00, 1, 1);
        chk("mul2.in_ready", 32'(in_ready), 32'd1);
        drive(4'd2, 8'h01, 8'h01, 8'h00, 0, 1);
        tick();
        in_valid = 1'b0;
        chk_out("b2b_add", 1, 1, 8'h02, 0, 0);

        // kill three cycles into a MUL: nothing written, flags untouched.
        drive(4'd10, 8'hFF, 8'hFF, 8'h00, 0, 2);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill.in_ready", 32'(in_ready), 32'd1);
        chk("kill.busy",     32'(busy),     32'd0);
        n_wr = 0;
        for (int k = 0; k < 10; k++) begin
            if (wr_en) n_wr++;
            tick();
        end
        chk("kill.writes", 32'(n_wr), 32'd0);
        chk_out("kill", 0, 1, 8'h02, 0, 0);

        // Asynchronous reset in the middle of a MUL.
        drive(4'd10, 8'hFF, 8'hFF, 8'h00, 0, 3);
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        chk_out("rst_mul", 0, 0, 8'h00, 0, 0);
        chk("rst_mul.in_ready", 32'(in_ready), 32'd1);
        chk("rst_mul.busy",     32'(busy),     32'd0);
        @(negedge clk) rst = 1'b1;
        tick();
        n_wr = 0;
        for (int k = 0; k < 10; k++) begin
            if (wr_en) n_wr++;
            tick();
        end
        chk("rst_mul.writes", 32'(n_wr), 32'd0);
        chk("rst_mul.data",   32'(wr_data), 32'h00);

        // Stage still operational after the reset.
        drive(4'd2, 8'h03, 8'h04, 8'h00, 0, 2);
        tick();
        in_valid = 1'b0;
        chk_out("post_rst", 1, 2, 8'h07, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage directly upstream of the register file write port.
- Consumes the two operands read from the register file, computes an ALU result, and drives the register file write port (wr_en, wr_addr, wr_data).
- Single-cycle ops have a registered result. MUL is an iterative shift-add unit with a valid/ready handshake that back-pressures issue.
- Also holds the Z/C flag register.

Parameters:
- WORD, 8, datapath width in bits; matches the register word size.
- ADDR_W, 2, register address width; matches the register file address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous and active-low.
- in_valid  input  1  an operation is presented this cycle.
- in_ready  output  1  stage can accept an operation this cycle.
- op  input  4  opcode: 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 SHL, 9 SHR, 10 MUL; 11-15 behave as NOP.
- src_a  input  WORD  operand A, from register file rd_data1.
- src_b  input  WORD  operand B, from register file rd_data2.
- imm  input  WORD  immediate operand.
- use_imm  input  1  1 = use imm in place of src_b.
- dst_addr  input  ADDR_W  destination register.
- kill  input  1  synchronous abort of the operation in flight.
- wr_en  output  1  register file write enable; a one-cycle pulse per result.
- wr_addr  output  ADDR_W  register file write address.
- wr_data  output  WORD  register file write data.
- flag_z  output  1  zero flag.
- flag_c  output  1  carry/borrow flag.
- busy  output  1  MUL iteration in progress.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0, flag_z=0, flag_c=0.
  - State goes to IDLE, so in_ready=1 and busy=0.
  - The iteration counter and the MUL accumulator/multiplicand/multiplier registers are cleared.
  - Releasing reset mid-MUL leaves no residue: the stage is in IDLE and no write occurs.
- Accept: an operation is accepted on a rising edge where in_valid=1, in_ready=1 and kill=0. Inputs are sampled only at acceptance.
- B operand: B = use_imm ? imm : src_b.
- States:
  - IDLE: in_ready=1.
  - Accept of a non-MUL op: stays in IDLE.
  - Accept of MUL: goes to MUL_RUN.
  - MUL_RUN: in_ready=0, busy=1. The counter loads WORD at accept and decrements each edge. When the counter reaches 1, the result is registered and the state returns to IDLE. kill=1 returns to IDLE immediately with no write and flags unchanged.
- Single-cycle latency: accept at edge N gives wr_en=1 with wr_addr/wr_data valid during cycle N+1. Back-to-back accepts give one write per cycle.
- MUL latency: accept at edge N gives wr_en=1 during cycle N+WORD.
  - in_ready is low in cycles N+1 .. N+WORD-1 and high in cycle N+WORD, allowing a back-to-back accept at edge N+WORD.
- MUL result: low WORD bits of A*B (unsigned); flag_c = (high WORD bits != 0).
- Other results and carry:
  - ADD: A+B, C = carry out.
  - SUB: A-B, C = borrow (A<B).
  - AND, OR, XOR: C=0.
  - NOT: ~A, C=0.
  - SHL: A<<1, C=A[WORD-1].
  - SHR: A>>1 logical, C=A[0].
  - MOV: B, C=0.
- flag_z = (result==0). Both flags update in the same edge that asserts wr_en.
- NOP: accepted, no wr_en, flags unchanged.
- wr_en is deasserted in every cycle that does not carry a fresh result. wr_addr/wr_data hold their last values.
- in_valid while in_ready=0 is ignored and not queued; the upstream stage holds its operation.
- kill while IDLE blocks acceptance that edge. A result already registered (wr_en high this cycle) is not retracted.
- All arithmetic is modulo 2^WORD and unsigned.

Test Plan:
- Reset: assert rst=0 mid-cycle with clk stopped -> immediately wr_en=0, wr_data=0x00, flag_z=0, flag_c=0, in_ready=1, busy=0.
- ADD: src_a=0xF0, src_b=0x20, dst_addr=1 -> one cycle later wr_en=1, wr_addr=1, wr_data=0x10, C=1, Z=0. Next cycle wr_en=0.
- SUB with immediate: src_a=0x05, imm=0x05, use_imm=1, dst_addr=2 -> wr_data=0x00, Z=1, C=0. Then SHR on src_a=0x01 -> 0x00, Z=1, C=1.
- MUL timing: 0x0D*0x0B, dst 3 -> in_ready=0 for 7 cycles, wr_en exactly 8 cycles after accept, wr_data=0x8F, C=0. Extra in_valid pulses during busy produce no writes.
- MUL overflow, back-to-back: 0x20*0x10 -> wr_data=0x00, Z=1, C=1. ADD 0x01+0x01 accepted on the MUL writeback edge -> 0x02 written the following cycle.
- Abort: kill=1 three cycles into a MUL -> no wr_en, flags unchanged, in_ready=1 next cycle. Repeat with rst=0 mid-MUL -> same, plus all outputs cleared.
